// File: rtl/vga_pixel_out.sv
// VGA timing generator and pixel output stage. It drives the pixel counters to the object mux,
// then registers its RGBIn colour together with sync flags delayed to match the mux latency.
module vga_pixel_out #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned MUX_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hSync,
  output logic        vSync
);

  localparam int unsigned HTotal     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncStart = H_VISIBLE + H_FRONT;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC - 1;
  localparam int unsigned VSyncStart = V_VISIBLE + V_FRONT;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC - 1;

  logic [10:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == 11'(HTotal - 1)) begin
      h_d = '0;
      v_d = (v_q == 11'(VTotal - 1)) ? '0 : v_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign pixelX = h_q;
  assign pixelY = v_q;
  // Counters already sit at (0,0) during reset; gate so the pulse only appears once running.
  assign startOfFrame = resetN && (h_q == '0) && (v_q == '0);

  logic vis_raw, hs_raw, vs_raw;
  logic vis_al, hs_al, vs_al;

  assign vis_raw = (h_q < 11'(H_VISIBLE)) && (v_q < 11'(V_VISIBLE));
  assign hs_raw  = !((h_q >= 11'(HSyncStart)) && (h_q <= 11'(HSyncEnd)));
  assign vs_raw  = !((v_q >= 11'(VSyncStart)) && (v_q <= 11'(VSyncEnd)));

  generate
    if (MUX_LATENCY == 0) begin : g_no_dly
      assign vis_al = vis_raw;
      assign hs_al  = hs_raw;
      assign vs_al  = vs_raw;
    end else begin : g_dly
      logic [MUX_LATENCY-1:0] dvis_q, dvis_d, dhs_q, dhs_d, dvs_q, dvs_d;

      always_comb begin
        dvis_d    = dvis_q;
        dhs_d     = dhs_q;
        dvs_d     = dvs_q;
        dvis_d[0] = vis_raw;
        dhs_d[0]  = hs_raw;
        dvs_d[0]  = vs_raw;
        for (int unsigned i = 1; i < MUX_LATENCY; i++) begin
          dvis_d[i] = dvis_q[i-1];
          dhs_d[i]  = dhs_q[i-1];
          dvs_d[i]  = dvs_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          dvis_q <= '0;
          dhs_q  <= '1;
          dvs_q  <= '1;
        end else begin
          dvis_q <= dvis_d;
          dhs_q  <= dhs_d;
          dvs_q  <= dvs_d;
        end
      end

      assign vis_al = dvis_q[MUX_LATENCY-1];
      assign hs_al  = dhs_q[MUX_LATENCY-1];
      assign vs_al  = dvs_q[MUX_LATENCY-1];
    end
  endgenerate

  logic [3:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    hsync_d = hs_al;
    vsync_d = vs_al;
    if (vis_al) begin
      // Replicate MSBs so full-scale input maps to full-scale DAC code.
      red_d   = {RGBIn[7:5], RGBIn[7]};
      green_d = {RGBIn[4:2], RGBIn[4]};
      blue_d  = {RGBIn[1:0], RGBIn[1:0]};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
  assign hSync = hsync_q;
  assign vSync = vsync_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out on a shrunk 32x20 raster (16x12 visible) so whole frames
// fit in a short run; a second instance with MUX_LATENCY = 0 runs alongside.
module tb_vga_pixel_out;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [7:0]  RGBIn = 8'h00;
  logic [10:0] pixelX, pixelY, px0, py0;
  logic        startOfFrame, sof0;
  logic [3:0]  red, green, blue, r0, g0, b0;
  logic        hSync, vSync, hs0, vs0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pixel_out #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4), .MUX_LATENCY(1)
  ) dut (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .red(red), .green(green), .blue(blue),
    .hSync(hSync), .vSync(vSync)
  );

  vga_pixel_out #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4), .MUX_LATENCY(0)
  ) dut0 (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .pixelX(px0), .pixelY(py0),
    .startOfFrame(sof0), .red(r0), .green(g0), .blue(b0),
    .hSync(hs0), .vSync(vs0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Releases reset and measures two frames with RGBIn held at 8'hE0.
  task automatic run_frames();
    int hs_f0 = -1, hs_f1 = -1, hs_w = -1, hs0_f = -1, px20 = -1, vs_f = -1, vs0_f = -1;
    int vs_low = 0, sof_cnt = 0, sof_t0 = -1, sof_t1 = -1;
    int bad_col = 0, bad_col0 = 0, vis_red = 0, bad_ctr0 = 0;
    logic prev_hs = 1'b1, prev_hs0 = 1'b1, prev_vs = 1'b1, prev_vs0 = 1'b1;
    int ax, ay;
    logic avis;
    RGBIn = 8'hE0;
    @(negedge clk);
    resetN = 1'b1;
    #1;
    for (int n = 0; n < 1320; n++) begin
      if (n <= 32) begin
        check_eq("px_seq", 32'(pixelX), n % 32);
        check_eq("py_seq", 32'(pixelY), (n == 32) ? 1 : 0);
        check_eq("sof_seq", 32'(startOfFrame), (n == 0) ? 1 : 0);
      end
      if (startOfFrame) begin
        sof_cnt++;
        if (sof_t0 < 0) sof_t0 = n;
        else if (sof_t1 < 0) sof_t1 = n;
      end
      if (px20 < 0 && pixelX == 11'd20) px20 = n;
      if (prev_hs && !hSync) begin
        if (hs_f0 < 0) hs_f0 = n;
        else if (hs_f1 < 0) hs_f1 = n;
      end
      if (!prev_hs && hSync && hs_w < 0 && hs_f0 >= 0) hs_w = n - hs_f0;
      if (prev_hs0 && !hs0 && hs0_f < 0) hs0_f = n;
      if (prev_vs && !vSync && vs_f < 0) vs_f = n;
      if (prev_vs0 && !vs0 && vs0_f < 0) vs0_f = n;
      if (n < 642 && !vSync) vs_low++;
      if (n >= 2) begin
        ax = (n - 2) % 32;
        ay = ((n - 2) / 32) % 20;
        avis = (ax < 16) && (ay < 12);
        if (red != (avis ? 4'hF : 4'h0) || green != 4'h0 || blue != 4'h0) bad_col++;
        if (n < 642 && red == 4'hF) vis_red++;
      end
      if (n >= 1) begin
        ax = (n - 1) % 32;
        ay = ((n - 1) / 32) % 20;
        avis = (ax < 16) && (ay < 12);
        if (r0 != (avis ? 4'hF : 4'h0) || g0 != 4'h0 || b0 != 4'h0) bad_col0++;
      end
      if (px0 != pixelX || py0 != pixelY || sof0 != startOfFrame) bad_ctr0++;
      prev_hs  = hSync;
      prev_hs0 = hs0;
      prev_vs  = vSync;
      prev_vs0 = vs0;
      @(negedge clk);
      #1;
    end
    check_eq("hs_low_width", hs_w, 6);
    check_eq("hs_period", hs_f1 - hs_f0, 32);
    check_eq("hs_fall_latency", hs_f0 - px20, 2);
    check_eq("hs_fall_latency_ml0", hs0_f - px20, 1);
    check_eq("vs_fall_time", vs_f, 14 * 32 + 2);
    check_eq("vs_fall_time_ml0", vs0_f, 14 * 32 + 1);
    check_eq("vs_low_width", vs_low, 64);
    check_eq("sof_period", sof_t1 - sof_t0, 640);
    check_eq("sof_count", sof_cnt, 3);
    check_eq("colour_masking", bad_col, 0);
    check_eq("colour_masking_ml0", bad_col0, 0);
    check_eq("visible_red_count", vis_red, 192);
    check_eq("counters_ml0", bad_ctr0, 0);
  endtask

  task automatic wait_xy(input int x, input int y, input string tag);
    int k = 0;
    while (!(pixelX == 11'(x) && pixelY == 11'(y)) && k < 1400) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq(tag, {10'd0, pixelY, pixelX}, {10'd0, 11'(y), 11'(x)});
  endtask

  // RGBIn for pixel (x,y) arrives one clock after the counter shows it.
  task automatic check_pixel(input int x, input int y, input logic [7:0] rgb,
                             input logic [11:0] exp, input string tag);
    wait_xy(x + 1, y, "wait_pixel");
    RGBIn = rgb;
    @(negedge clk);
    #1;
    check_eq(tag, 32'({red, green, blue}), 32'(exp));
    RGBIn = 8'h00;
  endtask

  initial begin
    #2 resetN = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_px", 32'(pixelX), 0);
    check_eq("rst_py", 32'(pixelY), 0);
    check_eq("rst_sof", 32'(startOfFrame), 0);
    check_eq("rst_rgb", 32'({red, green, blue}), 0);
    check_eq("rst_sync", 32'({hSync, vSync}), 32'h3);

    run_frames();

    check_pixel(10, 5, 8'b101_010_01, 12'hB45, "rgb_mixed_10_5");
    check_pixel(15, 11, 8'hFF, 12'hFFF, "rgb_last_visible");
    check_pixel(16, 3, 8'hFF, 12'h000, "rgb_x_past_visible");
    check_pixel(0, 12, 8'hFF, 12'h000, "rgb_y_past_visible");
    check_pixel(3, 7, 8'h1C, 12'h0F0, "rgb_green_only");
    check_pixel(4, 7, 8'h03, 12'h00F, "rgb_blue_only");
    check_pixel(5, 7, 8'b010_100_10, 12'h49A, "rgb_pattern_52");

    RGBIn = 8'hFF;
    wait_xy(7, 8, "wait_midframe");
    check_eq("pre_rst_rgb", 32'({red, green, blue}), 32'hFFF);
    #2 resetN = 1'b0;
    #1;
    check_eq("async_rst_px", 32'(pixelX), 0);
    check_eq("async_rst_py", 32'(pixelY), 0);
    check_eq("async_rst_sof", 32'(startOfFrame), 0);
    check_eq("async_rst_rgb", 32'({red, green, blue}), 0);
    check_eq("async_rst_sync", 32'({hSync, vSync}), 32'h3);

    run_frames();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
